shift_operand_pipe: RTL

Pipelined ARM shifter-operand unit producing Val2 and the shifter carry-out for the EXE stage. Generalises the combinational Val2 generator:
- parametrised data width
- register-specified shift amounts (Rs)
- ARM #0 special encodings (LSR/ASR #32, RRX)
- carry-out generation
- two-stage valid/ready pipeline with flush
Sits between ID/EXE register and ALU; ALU consumes out_val2/out_carry.

---
 rtl/shift_operand_pipe.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/shift_operand_pipe.sv
// Two-stage ARM shifter-operand unit: stage 1 decodes mode/type/amount, stage 2 shifts and holds Val2.
// Optional carry-out path (out_carry port and carry logic) is built when SHIFT_CARRY_EN is defined.
module shift_operand_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm,
  input  logic              in_mem_cmd,
  input  logic [11:0]       in_shift_op,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [7:0]        in_val_rs,
  input  logic              in_c_in,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val2,
`ifdef SHIFT_CARRY_EN
  output logic              out_carry,
`endif
  output logic [TAG_W-1:0]  out_tag
);

  localparam int LW = $clog2(DATA_W);
  localparam logic [15:0] W16 = 16'(DATA_W);

  typedef enum logic [1:0] {MODE_MEM, MODE_IMM, MODE_SHIFT} mode_e;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_e;

  function automatic logic [DATA_W-1:0] ror_f(input logic [DATA_W-1:0] x, input logic [LW-1:0] n);
    logic [2*DATA_W-1:0] d;
    d = {x, x} >> n;
    return d[DATA_W-1:0];
  endfunction

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  mode_e             s1_mode_q, s1_mode_d;
  shift_e            s1_type_q, s1_type_d;
  logic [7:0]        s1_amt_q, s1_amt_d;
  logic              s1_reg_amt_q, s1_reg_amt_d;
  logic [11:0]       s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_rm_q, s1_rm_d;
  logic              s1_c_q, s1_c_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic s1_move;
  logic accept;

  assign s1_move  = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || s1_move);
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_type_d    = s1_type_q;
    s1_amt_d     = s1_amt_q;
    s1_reg_amt_d = s1_reg_amt_q;
    s1_op_d      = s1_op_q;
    s1_rm_d      = s1_rm_q;
    s1_c_d       = s1_c_q;
    s1_tag_d     = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d   = 1'b1;
      s1_mode_d    = in_mem_cmd ? MODE_MEM : (in_imm ? MODE_IMM : MODE_SHIFT);
      s1_type_d    = shift_e'(in_shift_op[6:5]);
      s1_reg_amt_d = in_shift_op[4];
      s1_amt_d     = in_shift_op[4] ? in_val_rs : {3'b000, in_shift_op[11:7]};
      s1_op_d      = in_shift_op;
      s1_rm_d      = in_val_rm;
      s1_c_d       = in_c_in;
      s1_tag_d     = in_tag;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // Shifter datapath, evaluated from the stage-1 registers
  logic [15:0]              amt16;
  logic [LW-1:0]            amt_sh;
  logic                     amt_zero;
  logic                     amt_lt_w;
  logic                     rm_msb;
  logic [DATA_W-1:0]        lsl_res;
  logic [DATA_W-1:0]        lsr_res;
  logic signed [DATA_W-1:0] asr_res;
  logic [DATA_W-1:0]        ror_res;
  logic [DATA_W-1:0]        imm_res;
  logic [DATA_W-1:0]        res_val;

  assign amt16    = {8'h00, s1_amt_q};
  assign amt_sh   = LW'(s1_amt_q);
  assign amt_zero = (s1_amt_q == 8'd0);
  assign amt_lt_w = (amt16 < W16);
  assign rm_msb   = s1_rm_q[DATA_W-1];
  assign lsl_res  = s1_rm_q << amt_sh;
  assign lsr_res  = s1_rm_q >> amt_sh;
  assign asr_res  = $signed(s1_rm_q) >>> amt_sh;
  assign ror_res  = ror_f(s1_rm_q, amt_sh);
  assign imm_res  = ror_f(DATA_W'(s1_op_q[7:0]), LW'({s1_op_q[11:8], 1'b0}));

  always_comb begin
    res_val = s1_rm_q;
    case (s1_mode_q)
      MODE_MEM: res_val = DATA_W'(s1_op_q);
      MODE_IMM: res_val = imm_res;
      default: begin
        if (amt_zero) begin
          // Immediate #0 encodings mean LSR/ASR #DATA_W and RRX; register amount 0 passes Rm
          if (!s1_reg_amt_q) begin
            case (s1_type_q)
              SH_LSL:  res_val = s1_rm_q;
              SH_LSR:  res_val = '0;
              SH_ASR:  res_val = {DATA_W{rm_msb}};
              default: res_val = {s1_c_q, s1_rm_q[DATA_W-1:1]};
            endcase
          end
        end else if (amt_lt_w) begin
          case (s1_type_q)
            SH_LSL:  res_val = lsl_res;
            SH_LSR:  res_val = lsr_res;
            SH_ASR:  res_val = asr_res;
            default: res_val = ror_res;
          endcase
        end else begin
          case (s1_type_q)
            SH_LSL, SH_LSR: res_val = '0;
            SH_ASR:         res_val = {DATA_W{rm_msb}};
            default:        res_val = ror_res;
          endcase
        end
      end
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic [LW-1:0] lsl_idx;
  logic [LW-1:0] rsh_idx;
  logic          res_carry;
  logic          carry_q, carry_d;

  // Last bit out: Rm[DATA_W-n] for left shifts, Rm[n-1] for right shifts
  assign lsl_idx = LW'(0) - amt_sh;
  assign rsh_idx = amt_sh - LW'(1);

  always_comb begin
    res_carry = s1_c_q;
    case (s1_mode_q)
      MODE_MEM: res_carry = s1_c_q;
      MODE_IMM: res_carry = (s1_op_q[11:8] == 4'd0) ? s1_c_q : imm_res[DATA_W-1];
      default: begin
        if (amt_zero) begin
          if (!s1_reg_amt_q) begin
            case (s1_type_q)
              SH_LSL:         res_carry = s1_c_q;
              SH_LSR, SH_ASR: res_carry = rm_msb;
              default:        res_carry = s1_rm_q[0];
            endcase
          end
        end else if (amt_lt_w) begin
          case (s1_type_q)
            SH_LSL:         res_carry = s1_rm_q[lsl_idx];
            SH_LSR, SH_ASR: res_carry = s1_rm_q[rsh_idx];
            default:        res_carry = ror_res[DATA_W-1];
          endcase
        end else begin
          case (s1_type_q)
            SH_LSL:  res_carry = (amt16 == W16) ? s1_rm_q[0] : 1'b0;
            SH_LSR:  res_carry = (amt16 == W16) ? rm_msb : 1'b0;
            SH_ASR:  res_carry = rm_msb;
            default: res_carry = ror_res[DATA_W-1];
          endcase
        end
      end
    endcase
  end

  always_comb begin
    carry_d = carry_q;
    if (!flush && s1_move && s1_valid_q) carry_d = res_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign out_carry = carry_q;
`endif

  always_comb begin
    s2_valid_d = s2_valid_q;
    val2_d     = val2_q;
    tag_d      = tag_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_move) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        val2_d = res_val;
        tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= MODE_MEM;
      s1_type_q    <= SH_LSL;
      s1_amt_q     <= '0;
      s1_reg_amt_q <= 1'b0;
      s1_op_q      <= '0;
      s1_rm_q      <= '0;
      s1_c_q       <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      val2_q       <= '0;
      tag_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_type_q    <= s1_type_d;
      s1_amt_q     <= s1_amt_d;
      s1_reg_amt_q <= s1_reg_amt_d;
      s1_op_q      <= s1_op_d;
      s1_rm_q      <= s1_rm_d;
      s1_c_q       <= s1_c_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      val2_q       <= val2_d;
      tag_q        <= tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_val2  = val2_q;
  assign out_tag   = tag_q;

endmodule
